shift_expander: RTL and testbench
=================================

# shift_expander

Parametrised serial I/O expander controller for TinyQV peripherals. It drives one daisy-chained 74165 input shift-register chain and one 74595 output shift-register chain over a shared shift clock. Each transfer parallel-loads the 165 chain, shifts WIDTH bits out to the 595 chain while shifting WIDTH bits in, then latches the 595 outputs. It generalises fixed 24-bit board wiring to any chain length and shift rate, and adds a start/busy/done handshake and an auto-refresh mode.

## Interface
- WIDTH, 24: bits per chain (8 × number of cascaded '165/'595 devices); ≥1.
- DIV, 2: clk cycles per half-phase of sr_clk, sr_load_n and sr_latch pulses; ≥1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one transfer; sampled only in IDLE.
- auto  input  1  when 1, a new transfer begins automatically in the cycle after done.
- out_data  input  WIDTH  value to present on the 595 outputs; captured when a transfer starts.
- in_data  output  WIDTH  last value read from the 165 chain; updates only with done.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- sr_clk  output  1  shared shift clock (165 CP, 595 SRCLK); the chains act on its rising edge.
- sr_load_n  output  1  165 parallel load, active low.
- sr_latch  output  1  595 storage clock; the outputs update on its rising edge.
- sr_dout  output  1  serial data to the 595 chain, MSB first.
- sr_din  input  1  serial data from the last 165 QH, MSB first.

## Operation
- States: IDLE → LOAD → SHIFT → LATCH → IDLE.
- IDLE: sr_clk=0, sr_load_n=1, sr_latch=0, busy=0. If start=1, or auto=1 after a completed transfer, capture out_data into the TX shift register, clear the bit counter, and go to LOAD.
- LOAD: sr_load_n=0 for DIV cycles. sr_dout is driven with TX[WIDTH-1].
- SHIFT: for each bit k = 0..WIDTH-1:
  - Low phase: sr_clk=0 for DIV cycles, with sr_dout = current TX MSB.
  - In the last low-phase cycle, sample sr_din into the RX LSB (RX shifts left).
  - High phase: sr_clk=1 for DIV cycles. At the end of the high phase, shift TX left and increment the bit counter.
- After bit WIDTH-1's high phase, go to LATCH.
- LATCH: sr_clk=0 and sr_latch=1 for DIV cycles, then return to IDLE.
- On the IDLE entry cycle: done=1, in_data ← RX.
- RX order: the first sampled bit (165 QH straight after load) ends in in_data[WIDTH-1]. out_data[WIDTH-1] is shifted first and ends at the far end of the 595 chain.
- start=1 while busy is ignored; it is not queued.
- If start and auto are both high in the done cycle, exactly one new transfer starts.
- auto may change at any time; it only takes effect at the IDLE decision point.
- out_data changes during a transfer have no effect until the next capture.

## Timing
- Reset values: sr_clk=0, sr_load_n=1, sr_latch=0, sr_dout=0, busy=0, done=0, in_data=0, state=IDLE.
- Reset mid-transfer aborts immediately:
  - No further sr_clk edge or sr_latch pulse is produced.
  - The 595 outputs keep their previous latched value.
  - in_data is cleared to 0.
- Take the start-accept edge as cycle 0:
  - busy=1 and sr_load_n=0 during cycles 1..DIV.
  - First sr_clk rise at cycle DIV+DIV+1.
  - sr_latch rises at cycle DIV+2·DIV·WIDTH+1.
  - done=1 and busy=0 at cycle 2·DIV·(WIDTH+1)+1 (101 for the defaults).
- In auto mode, the transfer period is 2·DIV·(WIDTH+1)+1 cycles, including one IDLE/done cycle; busy drops for exactly that one cycle.
- All outputs are registered. sr_dout is stable for ≥DIV cycles before and DIV cycles after each sr_clk rise.
- sr_din is sampled ≥DIV cycles after the last 165 change, which covers the load or the previous shift edge.
- Counters:
  - Phase counter: $clog2(DIV+1) bits.
  - Bit counter: $clog2(WIDTH+1) bits.
  - DIV=1 and WIDTH=1 must work, with no zero-length phases.

## Test plan
- Default parameters, behavioural 165/595 models on the pins: out_data=24'hA5C3F0, 165 inputs=24'h123456, pulse start → done at cycle 101, in_data=24'h123456, 595 latched=24'hA5C3F0, exactly 24 sr_clk rises and 1 sr_latch rise.
- WIDTH=8, DIV=1: out_data=8'h81, inputs=8'h7E → done at cycle 19, in_data=8'h7E, latched=8'h81.
- auto=1 held, inputs changed 24'h000001→24'hFFFFFE between transfers → consecutive done pulses 101 cycles apart, in_data tracks each change, busy low for one cycle between transfers.
- start held high for 300 cycles with auto=0 → back-to-back transfers. A start pulse at cycle 50 of a transfer is ignored: no extra done and the counts are unchanged.
- rst asserted at cycle 60 of a transfer → next cycle all outputs are at their reset values. The 595 latched value is unchanged, and no sr_latch edge occurs.
- WIDTH=1, DIV=3: out_data=1, input=1 → done at cycle 13, in_data=1, latched=1.

Source files
------------

// File: rtl/shift_expander_if.sv
// shift_expander_if
//   Host-side handshake and data bundle for shift_expander.
//   start    : request one transfer (host -> controller)
//   auto     : re-arm a transfer automatically after each completion
//   out_data : value presented on the '595 outputs, captured at transfer start
//   in_data  : last value read from the '165 chain, updated with done
//   busy     : transfer in progress
//   done     : one-cycle completion pulse
interface shift_expander_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic             auto;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] in_data;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output auto,
        output out_data,
        input  in_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  auto,
        input  out_data,
        output in_data,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_expander.sv
// shift_expander
//   Serial I/O expander controller: one daisy-chained 74165 input chain and
//   one 74595 output chain sharing a single shift clock. A transfer
//   parallel-loads the '165 chain, clocks WIDTH bits out (MSB first) while
//   clocking WIDTH bits in (MSB first), then pulses the '595 storage clock.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        handshake/data bundle (start, auto, out_data, in_data, busy, done)
//   sr_clk     shared shift clock ('165 CP, '595 SRCLK)
//   sr_load_n  '165 parallel load, active low
//   sr_latch   '595 storage clock
//   sr_dout    serial data to the '595 chain
//   sr_din     serial data from the last '165 QH
//
// State  | meaning
// IDLE   | waiting for start (or auto re-arm right after a completion)
// LOAD   | '165 parallel load held low for DIV cycles
// SHIFT  | per bit: DIV cycles sr_clk low, then DIV cycles sr_clk high
// LATCH  | '595 storage clock high for DIV cycles
//
// All pin and handshake outputs are registered from the current state, so
// they trail the state register by one cycle. This keeps the pins glitch
// free and places the sr_din sample in the last cycle the pin clock is low.
module shift_expander #(
    parameter int WIDTH = 24,
    parameter int DIV   = 2
) (
    input  logic            clk,
    input  logic            rst,
    shift_expander_if.slave bus,
    output logic            sr_clk,
    output logic            sr_load_n,
    output logic            sr_latch,
    output logic            sr_dout,
    input  logic            sr_din
);
    localparam int PW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PH_INIT  = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ph, ph_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic             hi, hi_nxt;
    logic             fin, fin_nxt;
    logic [WIDTH-1:0] tx, tx_nxt;
    logic [WIDTH-1:0] rx, rx_nxt;
    logic [WIDTH-1:0] in_nxt;
    logic             busy_nxt, done_nxt, clk_nxt, load_n_nxt, latch_nxt, dout_nxt;
    logic             ph_tc;

    assign ph_tc = (ph == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ph          <= '0;
            bit_cnt     <= '0;
            hi          <= 1'b0;
            fin         <= 1'b0;
            tx          <= '0;
            rx          <= '0;
            bus.in_data <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            sr_clk      <= 1'b0;
            sr_load_n   <= 1'b1;
            sr_latch    <= 1'b0;
            sr_dout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ph          <= ph_nxt;
            bit_cnt     <= bit_nxt;
            hi          <= hi_nxt;
            fin         <= fin_nxt;
            tx          <= tx_nxt;
            rx          <= rx_nxt;
            bus.in_data <= in_nxt;
            bus.busy    <= busy_nxt;
            bus.done    <= done_nxt;
            sr_clk      <= clk_nxt;
            sr_load_n   <= load_n_nxt;
            sr_latch    <= latch_nxt;
            sr_dout     <= dout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        bit_nxt   = bit_cnt;
        hi_nxt    = hi;
        fin_nxt   = 1'b0;
        tx_nxt    = tx;
        rx_nxt    = rx;

        case (state)
            IDLE: begin
                // fin is only high in the first IDLE cycle, so auto re-arms
                // exactly once per completion and start+auto start one transfer.
                if (bus.start || (bus.auto && fin)) begin
                    tx_nxt    = bus.out_data;
                    bit_nxt   = '0;
                    ph_nxt    = PH_INIT;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ph_tc) begin
                    ph_nxt    = PH_INIT;
                    hi_nxt    = 1'b0;
                    state_nxt = SHIFT;
                end else begin
                    ph_nxt = ph - PW'(1);
                end
            end
            SHIFT: begin
                if (!hi) begin
                    if (ph_tc) begin
                        rx_nxt = (rx << 1) | WIDTH'(sr_din);
                        hi_nxt = 1'b1;
                        ph_nxt = PH_INIT;
                    end else begin
                        ph_nxt = ph - PW'(1);
                    end
                end else begin
                    if (ph_tc) begin
                        tx_nxt  = tx << 1;
                        bit_nxt = bit_cnt + BW'(1);
                        hi_nxt  = 1'b0;
                        ph_nxt  = PH_INIT;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = LATCH;
                        end
                    end else begin
                        ph_nxt = ph - PW'(1);
                    end
                end
            end
            LATCH: begin
                if (ph_tc) begin
                    state_nxt = IDLE;
                    fin_nxt   = 1'b1;
                end else begin
                    ph_nxt = ph - PW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt   = (state != IDLE);
        done_nxt   = (state == IDLE) && fin;
        in_nxt     = done_nxt ? rx : bus.in_data;
        load_n_nxt = (state != LOAD);
        clk_nxt    = (state == SHIFT) && hi;
        latch_nxt  = (state == LATCH);
        dout_nxt   = (state == IDLE) ? 1'b0 : tx[WIDTH-1];
    end
endmodule

// File: tb/tb_shift_expander.sv
// tb_shift_expander
//   Three controllers (24b/DIV2, 8b/DIV1, 1b/DIV3) each wired to behavioural
//   '165 and '595 chain models. Expected values come from the transfer rules:
//   read value = parallel inputs, latched value = out_data, done at
//   2*DIV*(WIDTH+1)+1 cycles after the accept edge, WIDTH clock rises and one
//   latch pulse per transfer.
module tb_shift_expander;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       start_v = '0;
    logic [2:0]       auto_v  = '0;
    logic [2:0][23:0] out_v   = '0;
    logic [2:0][23:0] pins_v  = '0;

    wire [2:0]       done_v, busy_v, sclk_v, load_v, latch_v, dout_v;
    wire [2:0][23:0] in_v, q_v;
    wire [2:0][15:0] rise_v, lat_v;

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int WG = (g == 0) ? 24 : ((g == 1) ? 8 : 1);
        localparam int DG = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        localparam logic [23:0] MASK = 24'((64'd1 << WG) - 64'd1);

        shift_expander_if #(.WIDTH(WG)) ifc ();

        logic [23:0] r165;
        logic [23:0] sh595;
        logic [23:0] q595;
        logic [15:0] rises = '0;
        logic [15:0] lats  = '0;

        assign ifc.start    = start_v[g];
        assign ifc.auto     = auto_v[g];
        assign ifc.out_data = out_v[g][WG-1:0];
        assign done_v[g]    = ifc.done;
        assign busy_v[g]    = ifc.busy;
        assign in_v[g]      = 24'(ifc.in_data);
        assign q_v[g]       = q595 & MASK;
        assign rise_v[g]    = rises;
        assign lat_v[g]     = lats;

        shift_expander #(.WIDTH(WG), .DIV(DG)) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (ifc),
            .sr_clk    (sclk_v[g]),
            .sr_load_n (load_v[g]),
            .sr_latch  (latch_v[g]),
            .sr_dout   (dout_v[g]),
            .sr_din    (r165[WG-1])
        );

        always @(posedge sclk_v[g] or negedge load_v[g]) begin
            if (!load_v[g]) r165 <= pins_v[g];
            else            r165 <= r165 << 1;
        end

        always @(posedge sclk_v[g]) begin
            sh595 <= {sh595[22:0], dout_v[g]};
            rises <= rises + 16'd1;
        end

        always @(posedge latch_v[g]) begin
            q595 <= sh595;
            lats <= lats + 16'd1;
        end
    end

    function automatic int wd(input int d);
        return (d == 0) ? 24 : ((d == 1) ? 8 : 1);
    endfunction

    function automatic int dv(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic logic [23:0] msk(input int d);
        return 24'hFFFFFF >> (24 - wd(d));
    endfunction

    // Starts one transfer on controller d and returns the cycle (relative to
    // the accept edge) at which each event was first observed; -1 if never.
    task automatic xfer(input int d, input logic [23:0] od, input logic [23:0] pd,
                        output int t_done, output int t_busy, output int t_load,
                        output int t_clk, output int t_latch);
        out_v[d]  = od;
        pins_v[d] = pd;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        t_done = -1; t_busy = -1; t_load = -1; t_clk = -1; t_latch = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            if (t_busy  < 0 && busy_v[d])   t_busy  = c;
            if (t_load  < 0 && !load_v[d])  t_load  = c;
            if (t_clk   < 0 && sclk_v[d])   t_clk   = c;
            if (t_latch < 0 && latch_v[d])  t_latch = c;
            if (done_v[d]) begin
                t_done = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if ({busy_v[d], done_v[d], sclk_v[d], load_v[d], latch_v[d], dout_v[d]} !== 6'b000100) begin
                fails++;
                $display("FAIL reset_pins[%0d]: got %b expected 000100", d,
                         {busy_v[d], done_v[d], sclk_v[d], load_v[d], latch_v[d], dout_v[d]});
            end
            tests++;
            if (in_v[d] !== 24'h0) begin
                fails++;
                $display("FAIL reset_in_data[%0d]: got %h expected 000000", d, in_v[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input string nm, input int d,
                               input logic [23:0] od, input logic [23:0] pd);
        int td, tbz, tl, tc, tla, w, k;
        int r0, l0;
        w  = wd(d);
        k  = dv(d);
        r0 = int'(rise_v[d]);
        l0 = int'(lat_v[d]);
        xfer(d, od, pd, td, tbz, tl, tc, tla);
        tests++;
        if (td !== 2 * k * (w + 1) + 1) begin
            fails++; $display("FAIL %s done_cycle: got %0d expected %0d", nm, td, 2 * k * (w + 1) + 1);
        end
        tests++;
        if (tbz !== 1 || tl !== 1) begin
            fails++; $display("FAIL %s busy/load_start: got %0d/%0d expected 1/1", nm, tbz, tl);
        end
        tests++;
        if (tc !== 2 * k + 1) begin
            fails++; $display("FAIL %s first_sr_clk: got %0d expected %0d", nm, tc, 2 * k + 1);
        end
        tests++;
        if (tla !== k + 2 * k * w + 1) begin
            fails++; $display("FAIL %s latch_cycle: got %0d expected %0d", nm, tla, k + 2 * k * w + 1);
        end
        tests++;
        if (busy_v[d] !== 1'b0) begin
            fails++; $display("FAIL %s busy_at_done: got %b expected 0", nm, busy_v[d]);
        end
        tests++;
        if (in_v[d] !== (pd & msk(d))) begin
            fails++; $display("FAIL %s in_data: got %h expected %h", nm, in_v[d], pd & msk(d));
        end
        tests++;
        if (q_v[d] !== (od & msk(d))) begin
            fails++; $display("FAIL %s latched: got %h expected %h", nm, q_v[d], od & msk(d));
        end
        tests++;
        if (int'(rise_v[d]) - r0 !== w || int'(lat_v[d]) - l0 !== 1) begin
            fails++; $display("FAIL %s edge_counts: got rises %0d latches %0d expected %0d/1", nm,
                              int'(rise_v[d]) - r0, int'(lat_v[d]) - l0, w);
        end
    endtask

    task automatic test_random();
        int td, tbz, tl, tc, tla, d;
        logic [23:0] od, pd;
        for (int i = 0; i < 6; i++) begin
            d  = int'($urandom_range(0, 2));
            od = 24'($urandom);
            pd = 24'($urandom);
            xfer(d, od, pd, td, tbz, tl, tc, tla);
            tests++;
            if (td !== 2 * dv(d) * (wd(d) + 1) + 1 || in_v[d] !== (pd & msk(d)) || q_v[d] !== (od & msk(d))) begin
                fails++;
                $display("FAIL random[%0d] d=%0d: got done %0d in %h q %h expected done %0d in %h q %h",
                         i, d, td, in_v[d], q_v[d], 2 * dv(d) * (wd(d) + 1) + 1, pd & msk(d), od & msk(d));
            end
        end
    endtask

    task automatic test_auto();
        int dc[3];
        logic [23:0] din[3];
        int nd, lowcnt, extra;
        nd = 0; lowcnt = 0; extra = 0;
        dc = '{0, 0, 0};
        din = '{24'h0, 24'h0, 24'h0};
        out_v[0]  = 24'($urandom);
        pins_v[0] = 24'h000001;
        auto_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (c > 0 && !busy_v[0]) lowcnt++;
            if (done_v[0]) begin
                dc[nd]  = c;
                din[nd] = in_v[0];
                nd++;
                if (nd == 1) pins_v[0] = 24'hFFFFFE;
                if (nd == 2) auto_v[0] = 1'b0;
                if (nd == 3) break;
            end
        end
        tests++;
        if (nd !== 3 || dc[0] !== 101 || dc[1] - dc[0] !== 101 || dc[2] - dc[1] !== 101) begin
            fails++; $display("FAIL auto_period: got %0d pulses at %0d,%0d,%0d expected 3 at 101,202,303",
                              nd, dc[0], dc[1], dc[2]);
        end
        tests++;
        if (din[0] !== 24'h000001 || din[1] !== 24'hFFFFFE || din[2] !== 24'hFFFFFE) begin
            fails++; $display("FAIL auto_in_data: got %h,%h,%h expected 000001,fffffe,fffffe",
                              din[0], din[1], din[2]);
        end
        tests++;
        if (lowcnt !== 3) begin
            fails++; $display("FAIL auto_busy_low: got %0d low cycles expected 3", lowcnt);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++; $display("FAIL auto_stop: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int dc[3];
        int nd, r0, l0;
        logic [23:0] od, pd;
        nd = 0;
        dc = '{0, 0, 0};
        od = 24'($urandom);
        pd = 24'($urandom) | 24'h1;
        r0 = int'(rise_v[0]);
        l0 = int'(lat_v[0]);
        out_v[0]  = od;
        pins_v[0] = pd;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c >= 299) start_v[0] = 1'b0;
            if (done_v[0]) begin
                if (nd < 3) dc[nd] = c;
                nd++;
            end
        end
        tests++;
        if (nd !== 3 || dc[0] !== 101 || dc[1] !== 202 || dc[2] !== 303) begin
            fails++; $display("FAIL b2b_done: got %0d pulses at %0d,%0d,%0d expected 3 at 101,202,303",
                              nd, dc[0], dc[1], dc[2]);
        end
        tests++;
        if (int'(rise_v[0]) - r0 !== 72 || int'(lat_v[0]) - l0 !== 3) begin
            fails++; $display("FAIL b2b_counts: got rises %0d latches %0d expected 72/3",
                              int'(rise_v[0]) - r0, int'(lat_v[0]) - l0);
        end
        tests++;
        if (in_v[0] !== pd || q_v[0] !== od) begin
            fails++; $display("FAIL b2b_data: got in %h q %h expected in %h q %h", in_v[0], q_v[0], pd, od);
        end
    endtask

    task automatic test_ignore();
        int nd, td, r0, l0;
        logic [23:0] od, pd;
        nd = 0; td = -1;
        od = 24'($urandom);
        pd = 24'($urandom) | 24'h1;
        r0 = int'(rise_v[0]);
        l0 = int'(lat_v[0]);
        out_v[0]  = od;
        pins_v[0] = pd;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            start_v[0] = (c == 50);
            if (done_v[0]) begin
                nd++;
                if (td < 0) td = c;
            end
        end
        tests++;
        if (nd !== 1 || td !== 101) begin
            fails++; $display("FAIL ignore_start: got %0d done pulses first at %0d expected 1 at 101", nd, td);
        end
        tests++;
        if (int'(rise_v[0]) - r0 !== 24 || int'(lat_v[0]) - l0 !== 1 || in_v[0] !== pd) begin
            fails++; $display("FAIL ignore_counts: got rises %0d latches %0d in %h expected 24/1 in %h",
                              int'(rise_v[0]) - r0, int'(lat_v[0]) - l0, in_v[0], pd);
        end
    endtask

    task automatic test_reset_mid();
        int r60, l0, nd;
        logic [23:0] q0;
        nd  = 0;
        r60 = 0;
        q0  = q_v[0];
        l0  = int'(lat_v[0]);
        out_v[0]  = ~q0;
        pins_v[0] = 24'($urandom);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (c == 60) begin
                r60 = int'(rise_v[0]);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        tests++;
        if ({busy_v[0], done_v[0], sclk_v[0], load_v[0], latch_v[0], dout_v[0]} !== 6'b000100) begin
            fails++; $display("FAIL midreset_pins: got %b expected 000100",
                              {busy_v[0], done_v[0], sclk_v[0], load_v[0], latch_v[0], dout_v[0]});
        end
        tests++;
        if (in_v[0] !== 24'h0) begin
            fails++; $display("FAIL midreset_in_data: got %h expected 000000", in_v[0]);
        end
        rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) nd++;
        end
        tests++;
        if (nd !== 0 || int'(rise_v[0]) !== r60 || int'(lat_v[0]) !== l0) begin
            fails++; $display("FAIL midreset_abort: got active %0d rises %0d latches %0d expected 0/%0d/%0d",
                              nd, int'(rise_v[0]), int'(lat_v[0]), r60, l0);
        end
        tests++;
        if (q_v[0] !== q0) begin
            fails++; $display("FAIL midreset_latched: got %h expected %h", q_v[0], q0);
        end
    endtask

    initial begin
        test_reset();
        test_single("basic24", 0, 24'hA5C3F0, 24'h123456);
        test_single("w8_div1", 1, 24'h000081, 24'h00007E);
        test_single("w1_div3", 2, 24'h000001, 24'h000001);
        test_random();
        test_auto();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
